trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter DATA_LEN, default 32: width of PC and CSR data paths.
REQ-002 Parameter MCAUSE_ECALL, default 11: mcause value written on ecall (M-mode environment call).
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port rst, input, 1: reset is synchronous and active-high.
REQ-005 Port trap_valid, input, 1: decode presents a trap-class instruction.
REQ-006 Port trap_ready, output, 1: controller accepts a trap this cycle.
REQ-007 Port ecall, input, 1: qualifies trap_valid as ecall.
REQ-008 Port mret, input, 1: qualifies trap_valid as mret.
REQ-009 Port pc, input, DATA_LEN: PC of the trapping instruction.
REQ-010 Port mtvec_rdata, input, DATA_LEN: current mtvec from the CSR file.
REQ-011 Port mepc_rdata, input, DATA_LEN: current mepc from the CSR file.
REQ-012 Port mstatus_rdata, input, DATA_LEN: current mstatus from the CSR file.
REQ-013 Port csr_waddr, output, 12: CSR write address.
REQ-014 Port csr_wdata, output, DATA_LEN: CSR write data.
REQ-015 Port csr_wen, output, 1: CSR write strobe, one cycle per write.
REQ-016 Port redirect_valid, output, 1: fetch redirect request.
REQ-017 Port redirect_ready, input, 1: fetch accepts the redirect.
REQ-018 Port redirect_pc, output, DATA_LEN: redirect target.
REQ-019 Port unusual_flag, output, 1: high whenever state != IDLE; suppresses GPR/CSR writes in decode.

Function
REQ-020 States: IDLE, WR_EPC, WR_CAUSE, WR_STATUS, MRET_STATUS, REDIRECT; one-hot or binary encoding at implementer's choice.
REQ-021 trap_ready SHALL equal (state == IDLE); a trap is accepted when trap_valid & trap_ready & (ecall | mret).
REQ-022 trap_valid with neither ecall nor mret SHALL be ignored; state stays IDLE.
REQ-023 ecall and mret both high: ecall wins; mret is ignored.
REQ-024 On ecall accept: latch pc -> epc_q, mtvec_rdata -> tgt_q, mstatus_rdata -> stat_q; next state WR_EPC.
REQ-025 On mret accept: latch mepc_rdata -> tgt_q, mstatus_rdata -> stat_q; next state MRET_STATUS.
REQ-026 WR_EPC: csr_wen=1, csr_waddr=12'h341, csr_wdata=epc_q; next WR_CAUSE.
REQ-027 WR_CAUSE: csr_wen=1, csr_waddr=12'h342, csr_wdata=MCAUSE_ECALL zero-extended to DATA_LEN; next WR_STATUS.
REQ-028 WR_STATUS: csr_wen=1, csr_waddr=12'h300, csr_wdata=stat_q with bit7(MPIE)=stat_q[3], bit3(MIE)=0, bits[12:11](MPP)=2'b11, other bits unchanged; next REDIRECT.
REQ-029 MRET_STATUS: csr_wen=1, csr_waddr=12'h300, csr_wdata=stat_q with bit3(MIE)=stat_q[7], bit7(MPIE)=1, bits[12:11]=2'b11, others unchanged; next REDIRECT.
REQ-030 REDIRECT: redirect_valid=1, redirect_pc={tgt_q[DATA_LEN-1:2],2'b00} (direct mode only; mtvec MODE bits ignored); hold until redirect_ready, then IDLE.
REQ-031 redirect_valid and redirect_pc SHALL remain stable while redirect_valid & ~redirect_ready.
REQ-032 In IDLE and REDIRECT, csr_wen=0, csr_waddr=0, csr_wdata=0; redirect_valid=0 outside REDIRECT.
REQ-033 Latency: ecall accept to redirect_valid = 4 cycles; mret accept to redirect_valid = 2 cycles.
REQ-034 A new trap is accepted no earlier than the cycle after the REDIRECT handshake (state IDLE again).
REQ-035 Latched values SHALL not change after accept; CSR read ports are sampled only on accept.

Reset
REQ-036 rst high at a rising edge: state=IDLE, epc_q/tgt_q/stat_q=0; outputs next cycle: trap_ready=1, unusual_flag=0, csr_wen=0, redirect_valid=0.
REQ-037 rst mid-sequence aborts it; no further CSR writes or redirect from the aborted trap.
REQ-038 rst has priority over an accept in the same cycle.

Verification
REQ-039 ecall, pc=0x8000_0010, mtvec=0x8000_0103, mstatus=0x8 -> writes 0x341<=0x8000_0010, 0x342<=11, 0x300<=0x1880 on cycles +1..+3; redirect_pc=0x8000_0100 at +4.
REQ-040 mret, mepc=0x8000_0014, mstatus=0x1880 -> write 0x300<=0x1888 at +1; redirect_pc=0x8000_0014 at +2.
REQ-041 redirect_ready held low 5 cycles in REDIRECT -> redirect_valid/pc stable, trap_ready=0, no csr_wen; IDLE the cycle after ready.
REQ-042 ecall&mret together -> ecall sequence only; trap_valid without either -> no state change.
REQ-043 rst asserted in WR_CAUSE -> next cycle IDLE, csr_wen=0, no redirect; subsequent ecall runs a full clean sequence.
REQ-044 Back-to-back ecall held valid -> second accept only after first redirect handshake; unusual_flag high throughout each sequence.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: turns an accepted ecall/mret into CSR write strobes
// followed by a fetch redirect handshake.
module trap_ctrl #(
    parameter int unsigned DATA_LEN     = 32,
    parameter int unsigned MCAUSE_ECALL = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trap_valid,
    output logic                trap_ready,
    input  logic                ecall,
    input  logic                mret,
    input  logic [DATA_LEN-1:0] pc,
    input  logic [DATA_LEN-1:0] mtvec_rdata,
    input  logic [DATA_LEN-1:0] mepc_rdata,
    input  logic [DATA_LEN-1:0] mstatus_rdata,
    output logic [11:0]         csr_waddr,
    output logic [DATA_LEN-1:0] csr_wdata,
    output logic                csr_wen,
    output logic                redirect_valid,
    input  logic                redirect_ready,
    output logic [DATA_LEN-1:0] redirect_pc,
    output logic                unusual_flag
);

    localparam logic [11:0]         ADDR_MSTATUS = 12'h300;
    localparam logic [11:0]         ADDR_MEPC    = 12'h341;
    localparam logic [11:0]         ADDR_MCAUSE  = 12'h342;
    localparam logic [DATA_LEN-1:0] CAUSE_VAL    = DATA_LEN'(MCAUSE_ECALL);
    localparam logic [DATA_LEN-1:0] ALIGN_MASK   = ~DATA_LEN'(3);

    typedef enum logic [2:0] {
        IDLE,
        WR_EPC,
        WR_CAUSE,
        WR_STATUS,
        MRET_STATUS,
        REDIRECT
    } state_e;

    state_e              state_q;
    logic [DATA_LEN-1:0] tgt_q;
    logic [DATA_LEN-1:0] stat_q;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous mode.
    function automatic logic [DATA_LEN-1:0] ecall_status(input logic [DATA_LEN-1:0] s);
        logic [DATA_LEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and re-arm MPIE.
    function automatic logic [DATA_LEN-1:0] mret_status(input logic [DATA_LEN-1:0] s);
        logic [DATA_LEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Outputs are registered for the state being entered; the mepc write data
    // is captured straight from pc on accept, so no separate epc register is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            tgt_q          <= '0;
            stat_q         <= '0;
            trap_ready     <= 1'b1;
            unusual_flag   <= 1'b0;
            csr_wen        <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            csr_wen   <= 1'b0;
            csr_waddr <= '0;
            csr_wdata <= '0;
            case (state_q)
                IDLE: begin
                    if (trap_valid && ecall) begin
                        tgt_q        <= mtvec_rdata;
                        stat_q       <= mstatus_rdata;
                        state_q      <= WR_EPC;
                        trap_ready   <= 1'b0;
                        unusual_flag <= 1'b1;
                        csr_wen      <= 1'b1;
                        csr_waddr    <= ADDR_MEPC;
                        csr_wdata    <= pc;
                    end else if (trap_valid && mret) begin
                        tgt_q        <= mepc_rdata;
                        stat_q       <= mstatus_rdata;
                        state_q      <= MRET_STATUS;
                        trap_ready   <= 1'b0;
                        unusual_flag <= 1'b1;
                        csr_wen      <= 1'b1;
                        csr_waddr    <= ADDR_MSTATUS;
                        csr_wdata    <= mret_status(mstatus_rdata);
                    end
                end
                WR_EPC: begin
                    state_q   <= WR_CAUSE;
                    csr_wen   <= 1'b1;
                    csr_waddr <= ADDR_MCAUSE;
                    csr_wdata <= CAUSE_VAL;
                end
                WR_CAUSE: begin
                    state_q   <= WR_STATUS;
                    csr_wen   <= 1'b1;
                    csr_waddr <= ADDR_MSTATUS;
                    csr_wdata <= ecall_status(stat_q);
                end
                WR_STATUS, MRET_STATUS: begin
                    state_q        <= REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= tgt_q & ALIGN_MASK;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state_q        <= IDLE;
                        redirect_valid <= 1'b0;
                        redirect_pc    <= '0;
                        trap_ready     <= 1'b1;
                        unusual_flag   <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= '0;
                    trap_ready     <= 1'b1;
                    unusual_flag   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, trap_ready, ecall, mret;
    logic [31:0] pc, mtvec_rdata, mepc_rdata, mstatus_rdata;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wen, redirect_valid, redirect_ready, unusual_flag;
    logic [31:0] redirect_pc;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_ready(trap_ready),
        .ecall(ecall), .mret(mret), .pc(pc), .mtvec_rdata(mtvec_rdata),
        .mepc_rdata(mepc_rdata), .mstatus_rdata(mstatus_rdata),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .unusual_flag(unusual_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed outputs; redirect_pc only matters while redirect_valid is high.
    logic [79:0] obs;
    assign obs = {trap_ready, unusual_flag, csr_wen, csr_waddr, csr_wdata,
                  redirect_valid, redirect_valid ? redirect_pc : 32'h0};

    function automatic logic [79:0] vec(input logic tr, input logic uf, input logic wen,
                                        input logic [11:0] a, input logic [31:0] d,
                                        input logic rv, input logic [31:0] rpc);
        return {tr, uf, wen, a, d, rv, rpc};
    endfunction

    localparam logic [79:0] IDLE_V = {1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0};

    // Reference model: a trap is a list of pending CSR writes followed by one redirect.
    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t         m_wr[$];
    logic        m_owed = 1'b0;
    logic [31:0] m_pc   = 32'h0;

    function automatic logic [31:0] ecall_st(input logic [31:0] s);
        return (s & ~32'h1888) | (((s >> 3) & 32'h1) << 7) | 32'h1800;
    endfunction

    function automatic logic [31:0] mret_st(input logic [31:0] s);
        return (s & ~32'h1888) | 32'h1880 | (((s >> 7) & 32'h1) << 3);
    endfunction

    function automatic logic [79:0] model_vec();
        if (m_wr.size() > 0) return vec(1'b0, 1'b1, 1'b1, m_wr[0].addr, m_wr[0].data, 1'b0, 32'h0);
        if (m_owed)          return vec(1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, m_pc);
        return IDLE_V;
    endfunction

    task automatic model_edge();
        wr_t w;
        if (rst) begin
            m_wr.delete();
            m_owed = 1'b0;
        end else if (m_wr.size() == 0 && !m_owed) begin
            if (trap_valid && ecall) begin
                w = '{12'h341, pc};                      m_wr.push_back(w);
                w = '{12'h342, 32'd11};                  m_wr.push_back(w);
                w = '{12'h300, ecall_st(mstatus_rdata)}; m_wr.push_back(w);
                m_pc = mtvec_rdata & ~32'h3;
                m_owed = 1'b1;
            end else if (trap_valid && mret) begin
                w = '{12'h300, mret_st(mstatus_rdata)};  m_wr.push_back(w);
                m_pc = mepc_rdata & ~32'h3;
                m_owed = 1'b1;
            end
        end else if (m_wr.size() > 0) begin
            void'(m_wr.pop_front());
        end else if (redirect_ready) begin
            m_owed = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        trap_valid = 1'b0; ecall = 1'b0; mret = 1'b0; redirect_ready = 1'b1;
        pc = 32'h0; mtvec_rdata = 32'h0; mepc_rdata = 32'h0; mstatus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic scramble_csrs();
        pc = $urandom; mtvec_rdata = $urandom; mepc_rdata = $urandom; mstatus_rdata = $urandom;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL reset: got %h want %h", obs, IDLE_V);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_ecall();
        logic [79:0] ev[5];
        ev[0] = vec(1'b0, 1'b1, 1'b1, 12'h341, 32'h8000_0010, 1'b0, 32'h0);
        ev[1] = vec(1'b0, 1'b1, 1'b1, 12'h342, 32'd11, 1'b0, 32'h0);
        ev[2] = vec(1'b0, 1'b1, 1'b1, 12'h300, 32'h0000_1880, 1'b0, 32'h0);
        ev[3] = vec(1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 32'h8000_0100);
        ev[4] = IDLE_V;
        do_reset();
        trap_valid = 1'b1; ecall = 1'b1;
        pc = 32'h8000_0010; mtvec_rdata = 32'h8000_0103; mstatus_rdata = 32'h8;
        step();
        trap_valid = 1'b0; ecall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            scramble_csrs();
            n_checks++;
            if (obs !== ev[i]) $display("FAIL ecall cyc%0d: got %h want %h", i + 1, obs, ev[i]);
            else n_pass++;
            if (i < 4) step();
        end
    endtask

    task automatic test_mret();
        logic [79:0] ev[3];
        ev[0] = vec(1'b0, 1'b1, 1'b1, 12'h300, 32'h0000_1888, 1'b0, 32'h0);
        ev[1] = vec(1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 32'h8000_0014);
        ev[2] = IDLE_V;
        do_reset();
        trap_valid = 1'b1; mret = 1'b1;
        mepc_rdata = 32'h8000_0014; mstatus_rdata = 32'h1880;
        step();
        trap_valid = 1'b0; mret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            scramble_csrs();
            n_checks++;
            if (obs !== ev[i]) $display("FAIL mret cyc%0d: got %h want %h", i + 1, obs, ev[i]);
            else n_pass++;
            if (i < 2) step();
        end
    endtask

    task automatic test_stall();
        logic [79:0] rv;
        rv = vec(1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 32'h8000_0200);
        do_reset();
        redirect_ready = 1'b0;
        trap_valid = 1'b1; ecall = 1'b1;
        pc = 32'h0000_0400; mtvec_rdata = 32'h8000_0202; mstatus_rdata = 32'h0;
        step();
        step(); step(); step();
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (obs !== rv) $display("FAIL stall cyc%0d: got %h want %h", k, obs, rv);
            else n_pass++;
            if (k < 5) step();
        end
        trap_valid = 1'b0; ecall = 1'b0; redirect_ready = 1'b1;
        step();
        n_checks++;
        if (obs !== IDLE_V) $display("FAIL stall_release: got %h want %h", obs, IDLE_V);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [79:0] e;
        do_reset();
        trap_valid = 1'b1; ecall = 1'b1; mret = 1'b1;
        pc = 32'h1234_5678; mepc_rdata = 32'h0000_0040; mtvec_rdata = 32'h0000_0800;
        mstatus_rdata = 32'h0000_0088;
        step();
        e = vec(1'b0, 1'b1, 1'b1, 12'h341, 32'h1234_5678, 1'b0, 32'h0);
        n_checks++;
        if (obs !== e) $display("FAIL prio_first: got %h want %h", obs, e);
        else n_pass++;
        trap_valid = 1'b0; ecall = 1'b0; mret = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            e = model_vec();
            n_checks++;
            if (obs !== e) $display("FAIL prio_seq cyc%0d: got %h want %h", i + 2, obs, e);
            else n_pass++;
        end
        trap_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            scramble_csrs();
            step();
            n_checks++;
            if (obs !== IDLE_V) $display("FAIL unqualified cyc%0d: got %h want %h", i, obs, IDLE_V);
            else n_pass++;
        end
        trap_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [79:0] e;
        do_reset();
        trap_valid = 1'b1; ecall = 1'b1;
        pc = 32'h0000_1000; mtvec_rdata = 32'h0000_2000; mstatus_rdata = 32'h8;
        step();
        trap_valid = 1'b0; ecall = 1'b0;
        step();
        e = vec(1'b0, 1'b1, 1'b1, 12'h342, 32'd11, 1'b0, 32'h0);
        n_checks++;
        if (obs !== e) $display("FAIL rstmid_cause: got %h want %h", obs, e);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs !== IDLE_V) $display("FAIL rstmid_abort cyc%0d: got %h want %h", i, obs, IDLE_V);
            else n_pass++;
            step();
        end
        trap_valid = 1'b1; ecall = 1'b1;
        pc = 32'h0000_3004; mtvec_rdata = 32'h0000_5001; mstatus_rdata = 32'hFFFF_FFF7;
        step();
        trap_valid = 1'b0; ecall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            e = model_vec();
            n_checks++;
            if (obs !== e) $display("FAIL rstmid_rerun cyc%0d: got %h want %h", i + 1, obs, e);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] e;
        do_reset();
        trap_valid = 1'b1; ecall = 1'b1;
        for (int i = 0; i < 14; i++) begin
            scramble_csrs();
            step();
            e = model_vec();
            n_checks++;
            if (obs !== e) $display("FAIL b2b cyc%0d: got %h want %h", i, obs, e);
            else n_pass++;
        end
        trap_valid = 1'b0; ecall = 1'b0;
    endtask

    task automatic test_random();
        logic [79:0] e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 39) == 0);
            trap_valid     = $urandom_range(0, 1) == 1;
            ecall          = $urandom_range(0, 2) == 0;
            mret           = $urandom_range(0, 2) == 0;
            redirect_ready = $urandom_range(0, 3) != 0;
            scramble_csrs();
            step();
            e = model_vec();
            n_checks++;
            if (obs !== e) $display("FAIL random cyc%0d: got %h want %h", i, obs, e);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_ecall();
        test_mret();
        test_stall();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
